// File: rtl/vec_dot_engine_if.sv
// Operand-FIFO and control bundle for vec_dot_engine.
// The slave modport is the engine's view; master is the FIFO/control side.
interface vec_dot_engine_if #(
    parameter int unsigned DWIDTH    = 8,
    parameter int unsigned LEN_WIDTH = 8,
    parameter int unsigned ACC_WIDTH = 2 * DWIDTH + LEN_WIDTH
);
    logic                 start;
    logic [LEN_WIDTH-1:0] len;
    logic                 a_empty;
    logic [DWIDTH-1:0]    a_d;
    logic                 a_r_en;
    logic                 b_empty;
    logic [DWIDTH-1:0]    b_d;
    logic                 b_r_en;
    logic                 busy;
    logic                 done;
    logic [ACC_WIDTH-1:0] result;

    modport master (
        output start, len, a_empty, a_d, b_empty, b_d,
        input  a_r_en, b_r_en, busy, done, result
    );

    modport slave (
        input  start, len, a_empty, a_d, b_empty, b_d,
        output a_r_en, b_r_en, busy, done, result
    );
endinterface

// File: rtl/vec_dot_engine.sv
// Dot-product engine: pops len element pairs from two operand FIFOs, multiplies
// and accumulates them, then pulses done with the result.
// Build option: define VEC_DOT_SIGNED_EN for two's-complement operands.
module vec_dot_engine #(
    parameter int unsigned DWIDTH    = 8,
    parameter int unsigned LEN_WIDTH = 8,
    parameter int unsigned ACC_WIDTH = 2 * DWIDTH + LEN_WIDTH
) (
    input logic             clk,
    input logic             rst_l,
    vec_dot_engine_if.slave dot_io
);
    typedef enum logic [1:0] {StIdle, StRun, StDrain} state_e;

    state_e               state_q, state_d;
    logic [LEN_WIDTH-1:0] len_q, len_d;
    logic [LEN_WIDTH-1:0] issued_q, issued_d;
    logic [LEN_WIDTH-1:0] received_q, received_d;
    logic [ACC_WIDTH-1:0] acc_q, acc_d;
    logic [ACC_WIDTH-1:0] result_q, result_d;
    logic                 rd_vld_q;
    logic                 done_q, done_d;
    logic                 issue;
    logic [2*DWIDTH-1:0]  prod;
    logic [ACC_WIDTH-1:0] prod_ext;

`ifdef VEC_DOT_SIGNED_EN
    // Sign-extend to full product width so the truncated product is exact.
    assign prod = $signed({{DWIDTH{dot_io.a_d[DWIDTH-1]}}, dot_io.a_d}) *
                  $signed({{DWIDTH{dot_io.b_d[DWIDTH-1]}}, dot_io.b_d});
    assign prod_ext = {{(ACC_WIDTH - 2 * DWIDTH){prod[2*DWIDTH-1]}}, prod};
`else
    assign prod = {{DWIDTH{1'b0}}, dot_io.a_d} * {{DWIDTH{1'b0}}, dot_io.b_d};
    assign prod_ext = {{(ACC_WIDTH - 2 * DWIDTH){1'b0}}, prod};
`endif

    // Both FIFOs are popped together, only when both hold data.
    assign issue = (state_q == StRun) && !dot_io.a_empty && !dot_io.b_empty &&
                   (issued_q < len_q);

    assign dot_io.a_r_en = issue;
    assign dot_io.b_r_en = issue;
    assign dot_io.busy   = (state_q != StIdle);
    assign dot_io.done   = done_q;
    assign dot_io.result = result_q;

    // Next-state: start acceptance, read issue, accumulate and completion.
    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        issued_d   = issued_q;
        received_d = received_q;
        acc_d      = acc_q;
        result_d   = result_q;
        done_d     = 1'b0;

        if (issue) begin
            issued_d = issued_q + LEN_WIDTH'(1);
        end

        unique case (state_q)
            StIdle: begin
                if (dot_io.start) begin
                    if (dot_io.len != '0) begin
                        len_d      = dot_io.len;
                        acc_d      = '0;
                        issued_d   = '0;
                        received_d = '0;
                        state_d    = StRun;
                    end else begin
                        result_d = '0;
                        done_d   = 1'b1;
                    end
                end
            end
            StRun: begin
                if (issue && (issued_q + LEN_WIDTH'(1) == len_q)) begin
                    state_d = StDrain;
                end
            end
            StDrain: begin
            end
            default: state_d = StIdle;
        endcase

        // FIFO data is valid one cycle after the pop.
        if (rd_vld_q) begin
            acc_d      = acc_q + prod_ext;
            received_d = received_q + LEN_WIDTH'(1);
            if (received_q == len_q - LEN_WIDTH'(1)) begin
                result_d = acc_d;
                done_d   = 1'b1;
                state_d  = StIdle;
            end
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            state_q    <= StIdle;
            len_q      <= '0;
            issued_q   <= '0;
            received_q <= '0;
            acc_q      <= '0;
            result_q   <= '0;
            rd_vld_q   <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            issued_q   <= issued_d;
            received_q <= received_d;
            acc_q      <= acc_d;
            result_q   <= result_d;
            rd_vld_q   <= issue;
            done_q     <= done_d;
        end
    end
endmodule

// File: tb/tb_vec_dot_engine.sv
// Self-checking bench for vec_dot_engine with behavioural operand FIFOs
// and an arithmetic dot-product reference model.
`timescale 1ns/1ps
module tb_vec_dot_engine;
    localparam int unsigned DW = 8;
    localparam int unsigned LW = 8;
    localparam int unsigned AW = 2 * DW + LW;

    typedef struct {
        int            lat;
        int            pops;
        int            viol;
        int            mism;
        int            busy_bad;
        logic [AW-1:0] res;
        bit            timeout;
        logic          done_after;
    } op_t;

    logic clk = 1'b0;
    logic rst_l = 1'b0;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    vec_dot_engine_if #(.DWIDTH(DW), .LEN_WIDTH(LW), .ACC_WIDTH(AW)) dif ();

    vec_dot_engine #(.DWIDTH(DW), .LEN_WIDTH(LW), .ACC_WIDTH(AW)) dut (
        .clk    (clk),
        .rst_l  (rst_l),
        .dot_io (dif)
    );

    // Operand FIFOs: registered read data, empty updates on the pop edge.
    logic [DW-1:0] a_mem [4096];
    logic [DW-1:0] b_mem [4096];
    int   wr_ptr = 0;
    int   a_rd = 0;
    int   b_rd = 0;
    logic b_stall = 1'b0;

    assign dif.a_empty = (a_rd == wr_ptr);
    assign dif.b_empty = (b_rd == wr_ptr) || b_stall;

    always @(posedge clk) begin
        if (dif.a_r_en) begin
            dif.a_d <= a_mem[a_rd];
            a_rd    <= a_rd + 1;
        end
        if (dif.b_r_en) begin
            dif.b_d <= b_mem[b_rd];
            b_rd    <= b_rd + 1;
        end
    end

    task automatic push_pair(input logic [DW-1:0] a, input logic [DW-1:0] b);
        a_mem[wr_ptr] = a;
        b_mem[wr_ptr] = b;
        wr_ptr++;
    endtask

    function automatic logic [AW-1:0] ref_dot(input int base, input int n);
        longint s;
        s = 0;
        for (int i = 0; i < n; i++) begin
`ifdef VEC_DOT_SIGNED_EN
            s += longint'($signed(a_mem[base+i])) * longint'($signed(b_mem[base+i]));
`else
            s += longint'(a_mem[base+i]) * longint'(b_mem[base+i]);
`endif
        end
        return s[AW-1:0];
    endfunction

    // Drives one operation from a negedge and observes it until done.
    task automatic run_op(input int n, input bit pre, input int st_after, input int st_len,
                          input int poke_len, input int chain_len, output op_t o);
        int cnt;
        bit got;
        bit armed;
        bit used;
        int left;
        o = '{default: 0};
        cnt = 0; got = 0; armed = 0; used = 0; left = 0;
        if (!pre) begin
            dif.start = 1'b1;
            dif.len   = LW'(n);
        end
        while (!got && cnt < 300) begin
            @(posedge clk);
            cnt++;
            #1;
            if (cnt == 1) begin
                dif.start = 1'b0;
                dif.len   = LW'($urandom);
            end
            if (poke_len > 0 && cnt == 2) begin
                dif.start = 1'b1;
                dif.len   = LW'(poke_len);
            end
            if (poke_len > 0 && cnt == 3) dif.start = 1'b0;
            if (armed) begin
                b_stall = 1'b1;
                left    = st_len;
                armed   = 0;
            end else if (left > 0) begin
                left--;
                if (left == 0) b_stall = 1'b0;
            end
            @(negedge clk);
            if (dif.a_r_en !== dif.b_r_en) o.mism++;
            if (dif.a_r_en && (dif.a_empty || dif.b_empty)) o.viol++;
            if (dif.a_r_en) o.pops++;
            if (st_after > 0 && !used && o.pops == st_after) begin
                armed = 1;
                used  = 1;
            end
            if (dif.done === 1'b1) begin
                got   = 1;
                o.lat = cnt - 1;
                o.res = dif.result;
                if (dif.busy !== 1'b0) o.busy_bad++;
            end else if (dif.busy !== 1'b1) begin
                o.busy_bad++;
            end
        end
        o.timeout = !got;
        b_stall = 1'b0;
        if (got && chain_len > 0) begin
            dif.start = 1'b1;
            dif.len   = LW'(chain_len);
        end else begin
            @(negedge clk);
            o.done_after = dif.done;
        end
    endtask

    task automatic test_reset();
        dif.start = 1'b0;
        dif.len   = '0;
        rst_l     = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({dif.busy, dif.done, dif.a_r_en, dif.b_r_en} !== 4'b0000) begin
            failures++;
            $display("FAIL reset_ctrl got=%b exp=0000",
                     {dif.busy, dif.done, dif.a_r_en, dif.b_r_en});
        end
        checks++;
        if (dif.result !== '0) begin
            failures++;
            $display("FAIL reset_result got=%0d exp=0", dif.result);
        end
        rst_l = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic();
        op_t o;
        push_pair(8'd1, 8'd5); push_pair(8'd2, 8'd6);
        push_pair(8'd3, 8'd7); push_pair(8'd4, 8'd8);
        run_op(4, 0, 0, 0, 0, 0, o);
        checks++;
        if (o.timeout || o.res !== AW'(70)) begin
            failures++; $display("FAIL basic_result got=%0d exp=70", o.res);
        end
        checks++;
        if (o.lat !== 5) begin failures++; $display("FAIL basic_latency got=%0d exp=5", o.lat); end
        checks++;
        if (o.pops !== 4) begin failures++; $display("FAIL basic_pops got=%0d exp=4", o.pops); end
        checks++;
        if (o.busy_bad !== 0 || o.viol !== 0 || o.mism !== 0) begin
            failures++;
            $display("FAIL basic_busy_ren got=%0d/%0d/%0d exp=0/0/0", o.busy_bad, o.viol, o.mism);
        end
        checks++;
        if (o.done_after !== 1'b0) begin
            failures++; $display("FAIL basic_done_pulse got=%b exp=0", o.done_after);
        end
    endtask

    task automatic test_len_zero();
        op_t o;
        run_op(0, 0, 0, 0, 0, 0, o);
        checks++;
        if (o.timeout || o.res !== '0 || o.lat !== 0) begin
            failures++;
            $display("FAIL len0_done got=res %0d lat %0d exp=res 0 lat 0", o.res, o.lat);
        end
        checks++;
        if (o.pops !== 0 || o.done_after !== 1'b0) begin
            failures++;
            $display("FAIL len0_ren got=pops %0d done %b exp=pops 0 done 0", o.pops, o.done_after);
        end
    endtask

    task automatic test_max_operands();
        op_t o;
        logic [AW-1:0] exp;
`ifdef VEC_DOT_SIGNED_EN
        exp = AW'(3);
`else
        exp = AW'(195075);
`endif
        repeat (3) push_pair(8'd255, 8'd255);
        run_op(3, 0, 0, 0, 0, 0, o);
        checks++;
        if (o.timeout || o.res !== exp) begin
            failures++; $display("FAIL max_result got=%0d exp=%0d", o.res, exp);
        end
        checks++;
        if (o.lat !== 4) begin failures++; $display("FAIL max_latency got=%0d exp=4", o.lat); end
    endtask

    task automatic test_stall();
        op_t o;
        int base;
        logic [AW-1:0] exp;
        base = a_rd;
        repeat (4) push_pair(DW'($urandom), DW'($urandom));
        exp = ref_dot(base, 4);
        run_op(4, 0, 2, 3, 0, 0, o);
        checks++;
        if (o.timeout || o.res !== exp) begin
            failures++; $display("FAIL stall_result got=%0d exp=%0d", o.res, exp);
        end
        checks++;
        if (o.lat !== 8) begin failures++; $display("FAIL stall_latency got=%0d exp=8", o.lat); end
        checks++;
        if (o.viol !== 0 || o.pops !== 4) begin
            failures++;
            $display("FAIL stall_ren got=viol %0d pops %0d exp=viol 0 pops 4", o.viol, o.pops);
        end
    endtask

    task automatic test_back_to_back();
        op_t o;
        int base;
        logic [AW-1:0] exp1, exp2;
        base = a_rd;
        repeat (5) push_pair(DW'($urandom), DW'($urandom));
        exp1 = ref_dot(base, 3);
        exp2 = ref_dot(base + 3, 2);
        run_op(3, 0, 0, 0, 7, 2, o);
        checks++;
        if (o.timeout || o.res !== exp1 || o.pops !== 3 || o.lat !== 4) begin
            failures++;
            $display("FAIL b2b_first got=res %0d pops %0d lat %0d exp=res %0d pops 3 lat 4",
                     o.res, o.pops, o.lat, exp1);
        end
        run_op(2, 1, 0, 0, 0, 0, o);
        checks++;
        if (o.timeout || o.res !== exp2 || o.pops !== 2 || o.lat !== 3) begin
            failures++;
            $display("FAIL b2b_second got=res %0d pops %0d lat %0d exp=res %0d pops 2 lat 3",
                     o.res, o.pops, o.lat, exp2);
        end
    endtask

    task automatic test_random();
        op_t o;
        int n, base, sa, sl;
        logic [AW-1:0] exp;
        for (int it = 0; it < 10; it++) begin
            n = $urandom_range(1, 16);
            base = a_rd;
            for (int i = 0; i < n; i++) push_pair(DW'($urandom), DW'($urandom));
            exp = ref_dot(base, n);
            sa = 0; sl = 0;
            if (n > 1 && $urandom_range(0, 1) == 1) begin
                sa = $urandom_range(1, n - 1);
                sl = $urandom_range(1, 4);
            end
            run_op(n, 0, sa, sl, 0, 0, o);
            checks++;
            if (o.timeout || o.res !== exp || o.lat !== n + 1 + sl || o.pops !== n) begin
                failures++;
                $display("FAIL rand_op%0d got=res %0d lat %0d pops %0d exp=res %0d lat %0d pops %0d",
                         it, o.res, o.lat, o.pops, exp, n + 1 + sl, n);
            end
            checks++;
            if (o.viol !== 0 || o.mism !== 0 || o.busy_bad !== 0) begin
                failures++;
                $display("FAIL rand_ctrl%0d got=%0d/%0d/%0d exp=0/0/0", it, o.viol, o.mism,
                         o.busy_bad);
            end
        end
    endtask

    task automatic test_reset_midrun();
        op_t o;
        int pops, cnt, base;
        bit seen;
        logic [AW-1:0] exp;
        repeat (5) push_pair(DW'($urandom), DW'($urandom));
        dif.start = 1'b1;
        dif.len   = LW'(5);
        pops = 0; cnt = 0;
        while (pops < 2 && cnt < 50) begin
            @(posedge clk);
            #1;
            dif.start = 1'b0;
            cnt++;
            @(negedge clk);
            if (dif.a_r_en) pops++;
        end
        checks++;
        if (pops !== 2) begin failures++; $display("FAIL rst_mid_pops got=%0d exp=2", pops); end
        @(posedge clk);
        #1;
        rst_l = 1'b0;
        #1;
        checks++;
        if ({dif.busy, dif.done, dif.a_r_en, dif.b_r_en} !== 4'b0000 || dif.result !== '0) begin
            failures++;
            $display("FAIL rst_mid_outputs got=%b res %0d exp=0000 res 0",
                     {dif.busy, dif.done, dif.a_r_en, dif.b_r_en}, dif.result);
        end
        seen = 0;
        repeat (3) begin
            @(negedge clk);
            if (dif.done !== 1'b0) seen = 1;
        end
        rst_l = 1'b1;
        @(negedge clk);
        if (dif.done !== 1'b0) seen = 1;
        checks++;
        if (seen) begin failures++; $display("FAIL rst_mid_nodone got=1 exp=0"); end
        base = a_rd;
        repeat (2) push_pair(DW'($urandom), DW'($urandom));
        exp = ref_dot(base, 2);
        run_op(2, 0, 0, 0, 0, 0, o);
        checks++;
        if (o.timeout || o.res !== exp || o.lat !== 3) begin
            failures++;
            $display("FAIL rst_mid_fresh got=res %0d lat %0d exp=res %0d lat 3", o.res, o.lat, exp);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_len_zero();
        test_max_operands();
        test_stall();
        test_back_to_back();
        test_random();
        test_reset_midrun();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end
endmodule
